ascii_7seg_scanner: RTL and testbench



---
 rtl/ascii_7seg_scanner.sv | 182 ++++++++++++++++++
 tb/tb_ascii_7seg_scanner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_7seg_scanner.sv
// ascii_7seg_scanner: NUM_DIGITS-entry ASCII buffer time-multiplexed onto one shared 7-segment bus.
// Latency: seg/an/dp are registered one cycle behind the scan state; a write reaches seg two edges later.
// Backpressure: none, every write is accepted. Optional decimal point per digit: define ASCII7SEG_DP_EN.
module ascii_7seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [7:0]            char_in,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [2:0]            digit_idx
`ifdef ASCII7SEG_DP_EN
  ,
  input  logic                  dp_in,
  output logic                  dp
`endif
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

`ifdef ASCII7SEG_DP_EN
  localparam int EW = 9;   // {dp, ascii}
`else
  localparam int EW = 8;   // ascii only
`endif

  localparam logic [CW-1:0]         SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]            LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [EW-1:0]         SPACE_ENT  = EW'(8'h20);
  localparam logic [6:0]            SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_OFF     = (ACTIVE_LOW != 0);

  typedef enum logic [0:0] {SHOW, BLANK} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [EW-1:0]           char_q [NUM_DIGITS];
  logic [EW-1:0]           wr_ent;
  logic [EW-1:0]           cur_ent;
  logic [NUM_DIGITS-1:0]   an_on;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    dp_q, dp_d;

  // Active-high a..g glyph for an ASCII code; anything unlisted is blank.
  function automatic logic [6:0] glyph(input logic [7:0] c);
    logic [6:0] g;
    case (c)
      8'h30:        g = 7'h3F;
      8'h31:        g = 7'h06;
      8'h32:        g = 7'h5B;
      8'h33:        g = 7'h4F;
      8'h34:        g = 7'h66;
      8'h35:        g = 7'h6D;
      8'h36:        g = 7'h7D;
      8'h37:        g = 7'h07;
      8'h38:        g = 7'h7F;
      8'h39:        g = 7'h6F;
      8'h41, 8'h61: g = 7'h77;
      8'h42, 8'h62: g = 7'h7C;
      8'h43, 8'h63: g = 7'h39;
      8'h44, 8'h64: g = 7'h5E;
      8'h45, 8'h65: g = 7'h79;
      8'h46, 8'h66: g = 7'h71;
      8'h2D:        g = 7'h40;
      8'h5F:        g = 7'h08;
      default:      g = 7'h00;
    endcase
    return g;
  endfunction

`ifdef ASCII7SEG_DP_EN
  assign wr_ent = {dp_in, char_in};
`else
  assign wr_ent = char_in;
`endif

  // Character buffer: reset to spaces; out-of-range addresses match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) char_q[i] <= SPACE_ENT;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_addr == 3'(i)) char_q[i] <= wr_ent;
      end
    end
  end

  // Select the entry for the digit being scanned and build its one-hot enable.
  always_comb begin
    cur_ent = SPACE_ENT;
    an_on   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_ent  = char_q[i];
        an_on[i] = 1'b1;
      end
    end
  end

  // Scan state register: SHOW/BLANK, dwell counter, current digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next scan state and next output values; BLANK drives everything off to prevent ghosting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    seg_d   = SEG_OFF;
    an_d    = AN_OFF;
    dp_d    = DP_OFF;
    case (state_q)
      SHOW: begin
        seg_d = (ACTIVE_LOW != 0) ? ~glyph(cur_ent[7:0]) : glyph(cur_ent[7:0]);
        an_d  = (ACTIVE_LOW != 0) ? ~an_on : an_on;
`ifdef ASCII7SEG_DP_EN
        dp_d  = (ACTIVE_LOW != 0) ? ~cur_ent[8] : cur_ent[8];
`endif
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = BLANK;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SHOW;
      end
    endcase
  end

  // Output registers: all-off after reset, otherwise one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
      dp_q  <= DP_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

`ifdef ASCII7SEG_DP_EN
  assign dp = dp_q;
`else
  logic unused_dp;
  assign unused_dp = dp_q;
`endif

endmodule

// File: tb/tb_ascii_7seg_scanner.sv
// Testbench for ascii_7seg_scanner: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1.
// Expected outputs come from a cycle-count model of the scan (period = lit + blank) plus a glyph table.
// Builds with or without ASCII7SEG_DP_EN.
module tb_ascii_7seg_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int P  = RD + BC;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [7:0]    char_in;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [2:0]    digit_idx;
`ifdef ASCII7SEG_DP_EN
  logic          dp_in;
  logic          dp;
  logic          dp_drv;
  logic          mdp [ND];
  logic          exp_dp;
`endif

  ascii_7seg_scanner #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .char_in(char_in),
    .seg(seg), .an(an), .digit_idx(digit_idx)
`ifdef ASCII7SEG_DP_EN
    , .dp_in(dp_in), .dp(dp)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [7:0]    mbuf [ND];
  int            mstate;
  logic [6:0]    exp_seg;
  logic [ND-1:0] exp_an;
  logic [2:0]    exp_idx;

  logic [6:0] dig_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [6:0] hex_tab [6]  = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] ref_glyph(input logic [7:0] c);
    int k;
    k = int'(c) - 48;
    if (k >= 0 && k <= 9) return dig_tab[k];
    k = int'(c | 8'h20) - 97;
    if (k >= 0 && k <= 5) return hex_tab[k];
    if (c == 8'h2D) return 7'h40;
    if (c == 8'h5F) return 7'h08;
    return 7'h00;
  endfunction

  // Drive one cycle of inputs, predict the outputs after the coming edge, advance the model.
  task automatic cycle(input logic rst, input logic we, input logic [2:0] a, input logic [7:0] c);
    int d;
    reset = rst; wr_en = we; wr_addr = a; char_in = c;
`ifdef ASCII7SEG_DP_EN
    dp_in = dp_drv;
    exp_dp = 1'b1;
`endif
    if (rst) begin
      exp_seg = 7'h7F; exp_an = 4'hF; exp_idx = 3'd0;
      for (int i = 0; i < ND; i++) mbuf[i] = 8'h20;
`ifdef ASCII7SEG_DP_EN
      for (int i = 0; i < ND; i++) mdp[i] = 1'b0;
`endif
      mstate = 0;
    end else begin
      d = (mstate / P) % ND;
      if ((mstate % P) < RD) begin
        exp_seg = ~ref_glyph(mbuf[d]);
        exp_an  = ~(4'b0001 << d);
`ifdef ASCII7SEG_DP_EN
        exp_dp  = ~mdp[d];
`endif
      end else begin
        exp_seg = 7'h7F; exp_an = 4'hF;
      end
      if (we && int'(a) < ND) begin
        mbuf[int'(a)] = c;
`ifdef ASCII7SEG_DP_EN
        mdp[int'(a)] = dp_drv;
`endif
      end
      mstate++;
      exp_idx = 3'((mstate / P) % ND);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 3'd0, 8'h00);
    cycle(1'b1, 1'b0, 3'd0, 8'h00);
    n_checks++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", seg); else n_pass++;
    n_checks++; if (an !== 4'hF) $display("FAIL reset_an got %h want f", an); else n_pass++;
    n_checks++; if (digit_idx !== 3'd0) $display("FAIL reset_idx got %0d want 0", digit_idx); else n_pass++;
    for (int i = 0; i < 3 * P * ND; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 8'h00);
      n_checks++; if (seg !== 7'h7F) $display("FAIL blank_scan_seg cyc %0d got %h want 7f", i, seg); else n_pass++;
      n_checks++; if (an !== exp_an) $display("FAIL blank_scan_an cyc %0d got %b want %b", i, an, exp_an); else n_pass++;
      n_checks++; if (digit_idx !== exp_idx) $display("FAIL blank_scan_idx cyc %0d got %0d want %0d", i, digit_idx, exp_idx); else n_pass++;
    end
  endtask

  task automatic test_digits();
    for (int i = 0; i < ND; i++) cycle(1'b0, 1'b1, 3'(i), 8'(8'h31 + i));
    for (int i = 0; i < 2 * P * ND; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 8'h00);
      n_checks++; if (seg !== exp_seg || an !== exp_an) $display("FAIL digits cyc %0d got seg %h an %b want seg %h an %b", i, seg, an, exp_seg, exp_an); else n_pass++;
      if (exp_an == 4'b1110) begin
        n_checks++; if (seg !== 7'h79) $display("FAIL digit0_glyph got %h want 79", seg); else n_pass++;
      end
      if (exp_an == 4'b0111) begin
        n_checks++; if (seg !== 7'h19) $display("FAIL digit3_glyph got %h want 19", seg); else n_pass++;
      end
    end
  endtask

  task automatic test_letters();
    cycle(1'b0, 1'b1, 3'd1, 8'h61);
    cycle(1'b0, 1'b1, 3'd2, 8'h5A);
    for (int i = 0; i < 2 * P * ND; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 8'h00);
      n_checks++; if (seg !== exp_seg || an !== exp_an) $display("FAIL letters cyc %0d got seg %h an %b want seg %h an %b", i, seg, an, exp_seg, exp_an); else n_pass++;
      if (exp_an == 4'b1101) begin
        n_checks++; if (seg !== 7'h08) $display("FAIL letter_a got %h want 08", seg); else n_pass++;
      end
      if (exp_an == 4'b1011) begin
        n_checks++; if (seg !== 7'h7F) $display("FAIL letter_Z got %h want 7f", seg); else n_pass++;
      end
    end
  endtask

  task automatic test_bad_addr_and_lit_write();
    int d;
    cycle(1'b0, 1'b1, 3'd5, 8'h30);
    cycle(1'b0, 1'b1, 3'd7, 8'h30);
    for (int i = 0; i < P * ND; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 8'h00);
      n_checks++; if (seg !== exp_seg || an !== exp_an) $display("FAIL bad_addr cyc %0d got seg %h an %b want seg %h an %b", i, seg, an, exp_seg, exp_an); else n_pass++;
      if (exp_an == 4'b1110) begin
        n_checks++; if (seg !== 7'h79) $display("FAIL bad_addr_digit0 got %h want 79", seg); else n_pass++;
      end
    end
    for (int i = 0; i < P && (mstate % P) != 1; i++) cycle(1'b0, 1'b0, 3'd0, 8'h00);
    d = (mstate / P) % ND;
    cycle(1'b0, 1'b1, 3'(d), 8'h38);
    n_checks++; if (seg !== exp_seg) $display("FAIL lit_write_edge1 got %h want %h", seg, exp_seg); else n_pass++;
    cycle(1'b0, 1'b0, 3'd0, 8'h00);
    n_checks++; if (seg !== 7'h00) $display("FAIL lit_write_edge2 got %h want 00", seg); else n_pass++;
    n_checks++; if (an !== exp_an) $display("FAIL lit_write_an got %b want %b", an, exp_an); else n_pass++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < P * ND && (mstate % (P * ND)) != 2 * P + 2; i++) cycle(1'b0, 1'b0, 3'd0, 8'h00);
    n_checks++; if (an !== 4'b1011) $display("FAIL pre_reset_digit2 got %b want 1011", an); else n_pass++;
    cycle(1'b1, 1'b0, 3'd0, 8'h00);
    n_checks++; if (an !== 4'hF || seg !== 7'h7F) $display("FAIL mid_reset got seg %h an %b want seg 7f an 1111", seg, an); else n_pass++;
    n_checks++; if (digit_idx !== 3'd0) $display("FAIL mid_reset_idx got %0d want 0", digit_idx); else n_pass++;
    for (int i = 0; i < P * ND + 1; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 8'h00);
      n_checks++; if (seg !== 7'h7F) $display("FAIL post_reset_seg cyc %0d got %h want 7f", i, seg); else n_pass++;
      n_checks++; if (an !== exp_an) $display("FAIL post_reset_an cyc %0d got %b want %b", i, an, exp_an); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [8] = '{8'h30, 8'h39, 8'h41, 8'h66, 8'h2D, 8'h5F, 8'h20, 8'h47};
    logic       we, rst;
    logic [7:0] c;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      we  = ($urandom_range(0, 2) == 0);
      c   = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 8'($urandom);
      cycle(rst, we, 3'($urandom_range(0, 7)), c);
      n_checks++; if (seg !== exp_seg) $display("FAIL rand_seg cyc %0d got %h want %h", i, seg, exp_seg); else n_pass++;
      n_checks++; if (an !== exp_an) $display("FAIL rand_an cyc %0d got %b want %b", i, an, exp_an); else n_pass++;
      n_checks++; if (digit_idx !== exp_idx) $display("FAIL rand_idx cyc %0d got %0d want %0d", i, digit_idx, exp_idx); else n_pass++;
    end
  endtask

`ifdef ASCII7SEG_DP_EN
  task automatic test_dp();
    cycle(1'b1, 1'b0, 3'd0, 8'h00);
    n_checks++; if (dp !== 1'b1) $display("FAIL dp_reset got %b want 1", dp); else n_pass++;
    dp_drv = 1'b1;
    cycle(1'b0, 1'b1, 3'd0, 8'h35);
    dp_drv = 1'b0;
    for (int i = 0; i < 2 * P * ND; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 8'h00);
      n_checks++; if (dp !== exp_dp || seg !== exp_seg) $display("FAIL dp_scan cyc %0d got dp %b seg %h want dp %b seg %h", i, dp, seg, exp_dp, exp_seg); else n_pass++;
      if (exp_an == 4'b1110) begin
        n_checks++; if (seg !== 7'h12 || dp !== 1'b0) $display("FAIL dp_digit0 got seg %h dp %b want seg 12 dp 0", seg, dp); else n_pass++;
      end
      if (exp_an == 4'hF) begin
        n_checks++; if (dp !== 1'b1) $display("FAIL dp_blank got %b want 1", dp); else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; char_in = 8'h00;
`ifdef ASCII7SEG_DP_EN
    dp_drv = 1'b0; dp_in = 1'b0;
`endif
    for (int i = 0; i < ND; i++) mbuf[i] = 8'h20;
    mstate = 0;
    test_reset();
    test_digits();
    test_letters();
    test_bad_addr_and_lit_write();
    test_mid_reset();
    test_random();
`ifdef ASCII7SEG_DP_EN
    test_dp();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
